// File: rtl/wavetable_voice_sequencer_pkg.sv
// Shared types and helpers for the wavetable voice sequencer.
//   state_t      : sequencer FSM encoding
//   DEF_*        : default parameter values for the top module
//   saturate()   : clip a wide signed value to a signed range of width w
package wavetable_voice_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_PHASE_W    = 32;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_SAMPLE_W   = 16;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_GAIN_SHIFT = 2;

    // Working width for saturate(); callers sign-extend into it and truncate out.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] y,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (y > hi)
            return hi;
        else if (y < lo)
            return lo;
        else
            return y;
    endfunction

endpackage

// File: rtl/wavetable_voice_sequencer_lrclk_edge_sync.sv
// Brings an asynchronous frame clock into the clk domain and flags its
// rising edges.
//   clk        : destination clock
//   rst_n      : asynchronous active-low reset
//   async_in   : asynchronous level (e.g. lrclk)
//   rise_pulse : one-cycle pulse on each synchronized rising edge
module lrclk_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= async_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign rise_pulse = sync2 & ~sync_prev;

endmodule

// File: rtl/wavetable_voice_sequencer.sv
// Time-multiplexed wavetable playback controller. Each rising lrclk edge
// walks all voices, issues one wavetable read per enabled voice, sums the
// returned samples and publishes one saturated mix sample.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   lrclk             : frame clock (asynchronous)
//   cfg_*             : per-voice increment / enable / phase-clear write port
//   mem_rd, mem_addr  : wavetable read strobe and address
//   mem_rdata         : read data, valid MEM_LAT cycles after mem_rd
//   sample_out        : mixed sample, held between frames
//   sample_valid      : one-cycle pulse when sample_out updates
//   busy              : frame in progress
//   overrun, overrun_clr : sticky "frame edge while busy" flag and its clear
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a frame strobe
// ST_ISSUE  | one cycle per voice: read if enabled, otherwise skip
// ST_WAIT   | MEM_LAT cycles of read latency; accumulate on the last one
// ST_OUTPUT | scale, saturate and publish the mix
module wavetable_voice_sequencer
    import wavetable_voice_sequencer_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int GAIN_SHIFT = DEF_GAIN_SHIFT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          lrclk,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_inc,
    input  logic                          cfg_en,
    input  logic                          cfg_phase_clr,
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic signed [SAMPLE_W-1:0]    mem_rdata,
    output logic signed [SAMPLE_W-1:0]    sample_out,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t state;
    state_t state_next;

    logic                    frame_strobe;
    logic [VW-1:0]           v;
    logic [CNT_W-1:0]        wait_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_scaled;
    logic [SAMPLE_W-1:0]     sample_next;
    logic                    last_voice;
    logic                    wait_done;

    logic [PHASE_W-1:0]      phase [NUM_VOICES];
    logic [PHASE_W-1:0]      inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0]   en;

    lrclk_edge_sync u_lrclk_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (lrclk),
        .rise_pulse (frame_strobe)
    );

    assign last_voice = (v == VW'(NUM_VOICES - 1));
    assign wait_done  = (wait_cnt == '0);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (frame_strobe)
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (en[v])
                    state_next = ST_WAIT;
                else if (last_voice)
                    state_next = ST_OUTPUT;
            end
            ST_WAIT: begin
                if (wait_done)
                    state_next = last_voice ? ST_OUTPUT : ST_ISSUE;
            end
            ST_OUTPUT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        busy     = (state != ST_IDLE);
        if (state == ST_ISSUE && en[v]) begin
            mem_rd   = 1'b1;
            mem_addr = phase[v][PHASE_W-1 -: ADDR_W];
        end
    end

    // Per-voice configuration and phase accumulators. The config write is
    // placed after the ISSUE increment so a same-cycle phase clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
            end
            en <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (state == ST_ISSUE && en[i] && v == VW'(i))
                    phase[i] <= phase[i] + inc[i];
                if (cfg_we && cfg_voice == VW'(i)) begin
                    inc[i] <= cfg_inc;
                    en[i]  <= cfg_en;
                    if (cfg_phase_clr)
                        phase[i] <= '0;
                end
            end
        end
    end

    assign acc_scaled  = acc >>> GAIN_SHIFT;
    assign sample_next = SAMPLE_W'(saturate(SAT_W'(acc_scaled), SAMPLE_W));

    // Voice walk, latency down-counter, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v            <= '0;
            wait_cnt     <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_strobe) begin
                        acc <= '0;
                        v   <= '0;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= CNT_W'(MEM_LAT - 1);
                    if (!en[v] && !last_voice)
                        v <= v + VW'(1);
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        acc <= acc + ACC_W'(mem_rdata);
                        if (!last_voice)
                            v <= v + VW'(1);
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    sample_out   <= sample_next;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun; a new set event takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (frame_strobe && state != ST_IDLE)
            overrun <= 1'b1;
        else if (overrun_clr)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_wavetable_voice_sequencer.sv
module tb_wavetable_voice_sequencer;

    logic               clk;
    logic               rst_n;
    logic               lrclk;
    logic               cfg_we;
    logic [2:0]         cfg_voice;
    logic [31:0]        cfg_inc;
    logic               cfg_en;
    logic               cfg_phase_clr;
    logic               mem_rd;
    logic [9:0]         mem_addr;
    logic signed [15:0] mem_rdata;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               busy;
    logic               overrun;
    logic               overrun_clr;

    int errors = 0;
    int checks = 0;

    int          rom_mode = 0;
    logic [15:0] pipe0, pipe1;
    logic [9:0]  addr_log [256];
    int          rd_cnt    = 0;
    int          valid_cnt = 0;

    wavetable_voice_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lrclk         (lrclk),
        .cfg_we        (cfg_we),
        .cfg_voice     (cfg_voice),
        .cfg_inc       (cfg_inc),
        .cfg_en        (cfg_en),
        .cfg_phase_clr (cfg_phase_clr),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [15:0] rom(input logic [9:0] a);
        case (rom_mode)
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            default: return {6'b0, a};
        endcase
    endfunction

    // Two-cycle-latency wavetable; garbage outside the valid slot.
    always @(posedge clk) begin
        pipe1 <= pipe0;
        pipe0 <= mem_rd ? rom(mem_addr) : 16'hDEAD;
    end
    assign mem_rdata = pipe1;

    always @(negedge clk) begin
        if (mem_rd) begin
            if (rd_cnt < 256) addr_log[rd_cnt] = mem_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (sample_valid) valid_cnt = valid_cnt + 1;
    end

    task automatic cfg_write(input logic [2:0] vc, input logic [31:0] inc,
                             input logic en, input logic clr);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_voice = vc; cfg_inc = inc; cfg_en = en; cfg_phase_clr = clr;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
    endtask

    task automatic disable_all();
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 32'h0, 1'b0, 1'b1);
    endtask

    // cyc = clk edges from the lrclk rise to the cycle showing sample_valid
    // (two synchronizer edges + frame cycle index); -1 on timeout.
    task automatic run_frame(output int cyc);
        @(posedge clk); #1;
        lrclk = 1'b1;
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (sample_valid) begin cyc = i; break; end
        end
        lrclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; lrclk = 0; cfg_we = 0; cfg_voice = 0; cfg_inc = 0;
        cfg_en = 0; cfg_phase_clr = 0; overrun_clr = 0;
        #5 rst_n = 1'b0;
        #30;
        checks++; if (sample_out !== 16'sd0) begin errors++; $display("FAIL reset_sample_out got=%h exp=0", sample_out); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got=%b exp=0", sample_valid); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single_voice();
        int cyc, r0;
        rom_mode = 0;
        cfg_write(3'd0, 32'h0040_0000, 1'b1, 1'b1);
        for (int f = 0; f < 5; f++) begin
            r0 = rd_cnt;
            run_frame(cyc);
            checks++; if (cyc !== 14) begin errors++; $display("FAIL single_timing f=%0d got=%0d exp=14", f, cyc); end
            checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL single_reads f=%0d got=%0d exp=1", f, rd_cnt - r0); end
            checks++; if (addr_log[r0] !== 10'(f)) begin errors++; $display("FAIL single_addr f=%0d got=%h exp=%h", f, addr_log[r0], f); end
            checks++; if (sample_out !== 16'(f >> 2)) begin errors++; $display("FAIL single_sample f=%0d got=%h exp=%h", f, sample_out, f >> 2); end
        end
    endtask

    task automatic test_saturation();
        int cyc, r0;
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 32'h0, 1'b1, 1'b1);
        rom_mode = 1;
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (cyc !== 28) begin errors++; $display("FAIL sat_timing got=%0d exp=28", cyc); end
        checks++; if (rd_cnt - r0 !== 8) begin errors++; $display("FAIL sat_reads got=%0d exp=8", rd_cnt - r0); end
        checks++; if (sample_out !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos got=%h exp=7fff", sample_out); end
        rom_mode = 2;
        run_frame(cyc);
        checks++; if (sample_out !== 16'sh8000) begin errors++; $display("FAIL sat_neg got=%h exp=8000", sample_out); end
        disable_all();
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL zero_voice_timing got=%0d exp=12", cyc); end
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL zero_voice_reads got=%0d exp=0", rd_cnt - r0); end
        checks++; if (sample_out !== 16'sd0) begin errors++; $display("FAIL zero_voice_sample got=%h exp=0", sample_out); end
    endtask

    task automatic test_phase_wrap();
        int cyc, r0;
        logic [9:0] ea;
        rom_mode = 0;
        disable_all();
        cfg_write(3'd1, 32'h8000_0000, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            ea = (f % 2 == 1) ? 10'h200 : 10'h000;
            r0 = rd_cnt;
            run_frame(cyc);
            checks++; if (rd_cnt - r0 !== 1 || addr_log[r0] !== ea) begin errors++; $display("FAIL wrap_addr f=%0d got=%h exp=%h", f, addr_log[r0], ea); end
            checks++; if (sample_out !== 16'(ea >> 2)) begin errors++; $display("FAIL wrap_sample f=%0d got=%h exp=%h", f, sample_out, ea >> 2); end
        end
    endtask

    task automatic test_overrun();
        int r0, vc0;
        rom_mode = 1;
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 32'h0, 1'b1, 1'b1);
        @(posedge clk); #1;
        r0 = rd_cnt; vc0 = valid_cnt;
        lrclk = 1'b1;
        repeat (5) @(posedge clk); #1;
        lrclk = 1'b0;
        repeat (5) @(posedge clk); #1;
        lrclk = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        repeat (50) @(posedge clk); #1;
        checks++; if (valid_cnt - vc0 !== 1) begin errors++; $display("FAIL overrun_frames got=%0d exp=1", valid_cnt - vc0); end
        checks++; if (rd_cnt - r0 !== 8) begin errors++; $display("FAIL overrun_reads got=%0d exp=8", rd_cnt - r0); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
        lrclk = 1'b0;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_idle got=%b exp=0", busy); end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_cfg_collision();
        int cyc, r0;
        logic got;
        rom_mode = 0;
        disable_all();
        cfg_write(3'd3, 32'h0100_0000, 1'b1, 1'b1);
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (cyc !== 14 || addr_log[r0] !== 10'd0) begin errors++; $display("FAIL coll_pre cyc=%0d addr=%h exp=14/0", cyc, addr_log[r0]); end
        @(posedge clk); #1;
        lrclk = 1'b1;
        repeat (6) @(posedge clk); #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 10'd4) begin errors++; $display("FAIL coll_old_addr rd=%b addr=%h exp=1/004", mem_rd, mem_addr); end
        cfg_we = 1'b1; cfg_voice = 3'd3; cfg_inc = 32'h0200_0000; cfg_en = 1'b1; cfg_phase_clr = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sample_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (got !== 1'b1 || sample_out !== 16'sd1) begin errors++; $display("FAIL coll_sample valid=%b got=%h exp=0001", got, sample_out); end
        lrclk = 1'b0;
        repeat (4) @(posedge clk);
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (addr_log[r0] !== 10'd0) begin errors++; $display("FAIL coll_phase_clr got=%h exp=000", addr_log[r0]); end
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (addr_log[r0] !== 10'd8) begin errors++; $display("FAIL coll_new_inc got=%h exp=008", addr_log[r0]); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc, r0, vc0;
        rom_mode = 1;
        for (int i = 0; i < 8; i++) cfg_write(3'(i), 32'h0040_0000, 1'b1, 1'b1);
        run_frame(cyc);
        checks++; if (sample_out !== 16'sh7FFF) begin errors++; $display("FAIL rmid_pre got=%h exp=7fff", sample_out); end
        @(posedge clk); #1;
        lrclk = 1'b1;
        vc0 = valid_cnt;
        repeat (16) @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL rmid_in_wait busy=%b rd=%b exp=1/0", busy, mem_rd); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (sample_out !== 16'sd0) begin errors++; $display("FAIL rmid_sample got=%h exp=0", sample_out); end
        checks++; if (mem_rd !== 1'b0 || mem_addr !== 10'd0) begin errors++; $display("FAIL rmid_mem rd=%b addr=%h exp=0/0", mem_rd, mem_addr); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", sample_valid); end
        lrclk = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++; if (valid_cnt !== vc0) begin errors++; $display("FAIL rmid_no_valid got=%0d exp=%0d", valid_cnt, vc0); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (cyc !== 12 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL rmid_cfg_cleared cyc=%0d reads=%0d exp=12/0", cyc, rd_cnt - r0); end
        rom_mode = 0;
        cfg_write(3'd0, 32'h0040_0000, 1'b1, 1'b0);
        r0 = rd_cnt;
        run_frame(cyc);
        checks++; if (cyc !== 14 || addr_log[r0] !== 10'd0) begin errors++; $display("FAIL rmid_fresh cyc=%0d addr=%h exp=14/000", cyc, addr_log[r0]); end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_saturation();
        test_phase_wrap();
        test_overrun();
        test_cfg_collision();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wavetable_voice_sequencer.md
Name: wavetable_voice_sequencer

Overview:
Time-multiplexed wavetable playback controller feeding the sample shift register in soundmodule. On each sample frame (rising lrclk), it steps through NUM_VOICES phase accumulators and issues one wavetable memory read per enabled voice. It sums the returned samples and presents one saturated mixed sample, held stable, as Din for the serializer. Voice pitch and enable are configured through a simple write port.

Parameters:
NUM_VOICES, 8, voices processed per frame (power of 2, >=2)
PHASE_W, 32, phase accumulator / increment width
ADDR_W, 10, wavetable address width; address = phase[PHASE_W-1 -: ADDR_W]
SAMPLE_W, 16, signed sample width (memory data and output)
MEM_LAT, 2, wavetable read latency in clk cycles (>=1)
GAIN_SHIFT, 2, arithmetic right shift applied to mix sum before saturation

Ports:
clk  in  1  50 MHz system clock
Reset  in  1  asynchronous, active-low reset
lrclk  in  1  44.1 kHz frame clock, asynchronous to clk
cfg_we  in  1  config write strobe
cfg_voice  in  clog2(NUM_VOICES)  voice index for write
cfg_inc  in  PHASE_W  phase increment (frequency word)
cfg_en  in  1  voice enable
cfg_phase_clr  in  1  zero the voice's phase on write
mem_rd  out  1  wavetable read strobe, one cycle
mem_addr  out  ADDR_W  wavetable read address
mem_rdata  in  SAMPLE_W  signed read data, valid exactly MEM_LAT cycles after mem_rd
sample_out  out  SAMPLE_W  mixed signed sample, held between frames
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: frame edge arrived while busy
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (Reset=0, async): state=IDLE; every phase, inc, en = 0; acc=0; sample_out=0; sample_valid=0; mem_rd=0; mem_addr=0; overrun=0; sync flops=0.
- lrclk passes through a 2-FF synchronizer plus an edge register; frame_strobe is a 1-cycle pulse on the synchronized rising edge only.
- States: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: on frame_strobe, set acc=0 and v=0, then go to ISSUE.
- ISSUE (1 cycle):
  - If en[v]=1: mem_rd=1; mem_addr=phase[v] top ADDR_W bits, using the pre-increment phase; phase[v] <= phase[v]+inc[v] mod 2^PHASE_W (wraps silently); go to WAIT.
  - If en[v]=0: no read, phase unchanged; advance v, or go to OUTPUT if v is the last voice.
- WAIT: count MEM_LAT cycles. In the last WAIT cycle, acc += sign-extend(mem_rdata); then advance v to ISSUE, or go to OUTPUT after the last voice.
- acc width is SAMPLE_W+clog2(NUM_VOICES) bits, signed; it never overflows.
- OUTPUT (1 cycle): compute y = acc >>> GAIN_SHIFT and saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. sample_out <= y and sample_valid <= 1 take effect on the next cycle. Go to IDLE.
- Timing: with frame_strobe in cycle 0, sample_valid is high in cycle 2 + E*(1+MEM_LAT) + D, where E = enabled voices and D = disabled voices. Defaults, all enabled: cycle 26.
- Zero enabled voices: sample_out=0 and sample_valid still pulses.
- frame_strobe while busy: strobe is ignored and overrun is set. If overrun_clr and a set event occur in the same cycle, set wins.
- Config write takes effect the next cycle, in any state. On a write, inc and en always update; the phase is zeroed only if cfg_phase_clr=1.
- A config write to the voice being incremented in ISSUE in the same cycle: the cfg write wins for phase (if clr) and for inc. The read address still uses the old phase.
- Reset asserted mid-frame aborts immediately to reset values; no sample_valid is produced.

Decomposition:
- synth_pkg: state enum (IDLE/ISSUE/WAIT/OUTPUT), default widths, and a saturate function.
- Sub-module lrclk_edge_sync: 2-FF synchronizer plus rising-edge pulse. It is reused wherever lrclk crosses into clk.
- Phase/inc/en storage and the datapath stay in the top module.

Test Plan:
1. Reset release, voice 0 only enabled with inc=0x0040_0000, ROM addr=data, one lrclk edge -> mem_addr 0 then 1 on successive frames; sample_out = 0 >>> 2 = 0, then 1 >>> 2 = 0; sample_valid high in cycle 2+3+7=12 after the strobe.
2. All 8 voices enabled, ROM returns 0x7FFF everywhere -> acc=262136, shifted=65534, sample_out=0x7FFF (saturated). With ROM returning 0x8000 -> sample_out=0x8000.
3. Phase wrap: inc=0x8000_0000, phase start 0 -> addresses alternate 0x000 and 0x200 every frame, with no glitch at wrap.
4. Second lrclk rising edge forced while busy -> overrun=1, no extra frame started. Pulse overrun_clr -> overrun returns to 0.
5. cfg_we with cfg_phase_clr to voice 3 while the FSM is in ISSUE for voice 3 -> phase[3]=0 next cycle, and this frame's mem_addr uses the old phase.
6. Reset deasserted-then-asserted in WAIT of voice 4 -> all outputs return to reset values immediately, with no sample_valid. After release, the next frame behaves as after a fresh reset.
